// File: rtl/cpu_types_pkg.sv
// Shared types for the multicycle MIPS-subset control path.
// Holds opcode/funct/ALU-op encodings, the control FSM state enum, the
// instruction class used to steer sequencing, the mux select encodings and
// the decoded-control struct produced by instr_decode.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE   = 6'h05, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI  = 6'h0F,
    OP_LW    = 6'h23, OP_SW    = 6'h2B, OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
    FN_AND = 6'h24, FN_OR  = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
    FN_SLT = 6'h2A, FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT
  } mc_state_t;

  // Sequencing class: which path the FSM takes after EXECUTE.
  typedef enum logic [2:0] {
    CL_ALU, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL
  } iclass_t;

  localparam logic [1:0] PCSEL_PC4  = 2'd0;
  localparam logic [1:0] PCSEL_BR   = 2'd1;
  localparam logic [1:0] PCSEL_JMP  = 2'd2;

  localparam logic [1:0] DST_RD     = 2'd0;
  localparam logic [1:0] DST_RT     = 2'd1;
  localparam logic [1:0] DST_R31    = 2'd2;

  localparam logic [1:0] WB_ALU     = 2'd0;
  localparam logic [1:0] WB_MEM     = 2'd1;
  localparam logic [1:0] WB_PC4     = 2'd2;

  localparam logic [1:0] BSEL_RT    = 2'd0;
  localparam logic [1:0] BSEL_SEXT  = 2'd1;
  localparam logic [1:0] BSEL_ZEXT  = 2'd2;
  localparam logic [1:0] BSEL_LUI   = 2'd3;

  typedef struct packed {
    aluop_t     aluop;
    logic       asel;
    logic [1:0] bsel;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    iclass_t    iclass;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder.
// Maps opcode/funct of the held instruction to ALU op, operand selects,
// writeback destination/source, sequencing class and an illegal flag.
// Ports: op, fn (instruction fields) in; dec (dec_t) out.
// Macro JAL_EN: when defined, opcode 0x03 decodes as JAL; otherwise it is
// treated as unsupported like any other unknown opcode.
module instr_decode
  import cpu_types_pkg::*;
(
  input  opcode_t op,
  input  funct_t  fn,
  output dec_t    dec
);

  always_comb begin
    dec         = '0;
    dec.aluop   = ALU_ADD;
    dec.bsel    = BSEL_RT;
    dec.reg_dst = DST_RT;
    dec.wb_sel  = WB_ALU;
    dec.iclass  = CL_ALU;
    case (op)
      OP_RTYPE: begin
        dec.reg_dst = DST_RD;
        case (fn)
          FN_SLL:  begin dec.aluop = ALU_SLL; dec.asel = 1'b1; end
          FN_SRL:  begin dec.aluop = ALU_SRL; dec.asel = 1'b1; end
          FN_ADDU: dec.aluop = ALU_ADD;
          FN_SUBU: dec.aluop = ALU_SUB;
          FN_AND:  dec.aluop = ALU_AND;
          FN_OR:   dec.aluop = ALU_OR;
          FN_XOR:  dec.aluop = ALU_XOR;
          FN_NOR:  dec.aluop = ALU_NOR;
          FN_SLT:  dec.aluop = ALU_SLT;
          FN_SLTU: dec.aluop = ALU_SLTU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDIU: begin dec.aluop = ALU_ADD;  dec.bsel = BSEL_SEXT; end
      OP_SLTI:  begin dec.aluop = ALU_SLT;  dec.bsel = BSEL_SEXT; end
      OP_SLTIU: begin dec.aluop = ALU_SLTU; dec.bsel = BSEL_SEXT; end
      OP_ANDI:  begin dec.aluop = ALU_AND;  dec.bsel = BSEL_ZEXT; end
      OP_ORI:   begin dec.aluop = ALU_OR;   dec.bsel = BSEL_ZEXT; end
      OP_XORI:  begin dec.aluop = ALU_XOR;  dec.bsel = BSEL_ZEXT; end
      // rs is forced to $0 by the datapath, so OR with {imm,16'h0} gives LUI
      OP_LUI:   begin dec.aluop = ALU_OR;   dec.bsel = BSEL_LUI;  end
      OP_LW: begin
        dec.iclass = CL_LW;
        dec.bsel   = BSEL_SEXT;
        dec.wb_sel = WB_MEM;
      end
      OP_SW: begin
        dec.iclass = CL_SW;
        dec.bsel   = BSEL_SEXT;
      end
      OP_BEQ: begin dec.iclass = CL_BEQ; dec.aluop = ALU_SUB; end
      OP_BNE: begin dec.iclass = CL_BNE; dec.aluop = ALU_SUB; end
      OP_J:   dec.iclass = CL_J;
`ifdef JAL_EN
      OP_JAL: begin
        dec.iclass  = CL_JAL;
        dec.reg_dst = DST_R31;
        dec.wb_sel  = WB_PC4;
      end
`endif
      // OP_HALT and everything unknown end up here
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the MIPS subset.
// Sequences FETCH -> DECODE -> EXECUTE -> MEMORY/WRITEBACK over a shared
// datapath; HALT is absorbing until reset.
// Ports: CLK, nRST (sync, active low); instr/ihit from instruction memory,
// dhit from data memory, zero from the ALU; ALUOP, alu_asel, alu_bsel,
// iREN, dREN, dWEN, pc_wen, pc_sel, reg_wen, reg_dst, wb_sel, halt out.
// Outputs are decoded from state + instruction register; pc_wen also
// follows ihit in FETCH and zero in EXECUTE. All outputs are held at zero
// (ALUOP = ALU_ADD) while nRST is low, which aborts any memory access.
// Macro JAL_EN (see instr_decode) enables the JAL instruction.
module multicycle_control
  import cpu_types_pkg::*;
#(
  parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] instr,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        zero,
  output aluop_t      ALUOP,
  output logic        alu_asel,
  output logic [1:0]  alu_bsel,
  output logic        iREN,
  output logic        dREN,
  output logic        dWEN,
  output logic        pc_wen,
  output logic [1:0]  pc_sel,
  output logic        reg_wen,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        halt
);

  mc_state_t   state;
  logic [31:0] ir;
  dec_t        dec;

  // Register/immediate fields are consumed by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^ir[25:6];

  instr_decode u_dec (
    .op  (opcode_t'(ir[31:26])),
    .fn  (funct_t'(ir[5:0])),
    .dec (dec)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= FETCH;
      ir    <= '0;
    end else begin
      case (state)
        FETCH: if (ihit) begin
          ir    <= instr;
          state <= DECODE;
        end
        DECODE: state <= dec.illegal ? HALT : EXECUTE;
        EXECUTE: begin
          case (dec.iclass)
            CL_ALU, CL_JAL: state <= WRITEBACK;
            CL_LW, CL_SW:   state <= MEMORY;
            default:        state <= FETCH;
          endcase
        end
        MEMORY: if (dhit) state <= (dec.iclass == CL_LW) ? WRITEBACK : FETCH;
        WRITEBACK: state <= FETCH;
        HALT:      state <= HALT;
        default:   state <= FETCH;
      endcase
    end
  end

  always_comb begin
    ALUOP    = ALU_ADD;
    alu_asel = 1'b0;
    alu_bsel = BSEL_RT;
    iREN     = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    pc_wen   = 1'b0;
    pc_sel   = RESET_PC_SEL;
    reg_wen  = 1'b0;
    reg_dst  = DST_RD;
    wb_sel   = WB_ALU;
    halt     = 1'b0;
    if (!nRST) begin
      pc_sel = '0;
    end else begin
      case (state)
        FETCH: begin
          iREN   = 1'b1;
          pc_wen = ihit;
          pc_sel = PCSEL_PC4;
        end
        EXECUTE: begin
          ALUOP    = dec.aluop;
          alu_asel = dec.asel;
          alu_bsel = dec.bsel;
          case (dec.iclass)
            CL_BEQ: begin pc_wen = zero;  pc_sel = PCSEL_BR; end
            CL_BNE: begin pc_wen = !zero; pc_sel = PCSEL_BR; end
            CL_J, CL_JAL: begin pc_wen = 1'b1; pc_sel = PCSEL_JMP; end
            default: ;
          endcase
        end
        // Operand selects stay put so the address stays stable until dhit.
        MEMORY: begin
          ALUOP    = dec.aluop;
          alu_asel = dec.asel;
          alu_bsel = dec.bsel;
          dREN     = (dec.iclass == CL_LW);
          dWEN     = (dec.iclass == CL_SW);
        end
        WRITEBACK: begin
          reg_wen = 1'b1;
          reg_dst = dec.reg_dst;
          wb_sel  = dec.wb_sel;
        end
        HALT:    halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed cases plus randomized instruction
// streams with random ihit/dhit wait states, compared against a
// cycle-budget model derived from instruction latency rules.
module tb_multicycle_control;
  import cpu_types_pkg::*;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3,
                 K_BEQ = 4, K_BNE = 5, K_J = 6, K_JAL = 7;

  typedef struct {
    string      name;
    logic [5:0] opc;
    logic [5:0] fn;
    int         kind;
    aluop_t     aop;
    logic       asel;
    logic [1:0] bsel;
  } op_t;

  logic        CLK = 1'b0, nRST = 1'b0, ihit = 1'b0, dhit = 1'b0, zero = 1'b0;
  logic [31:0] instr = '0;
  aluop_t      ALUOP;
  logic        alu_asel, iREN, dREN, dWEN, pc_wen, reg_wen, halt;
  logic [1:0]  alu_bsel, pc_sel, reg_dst, wb_sel;

  int  n_tests = 0, n_fail = 0;
  op_t ops[$];

  always #5 CLK = ~CLK;

  multicycle_control dut (
    .CLK(CLK), .nRST(nRST), .instr(instr), .ihit(ihit), .dhit(dhit),
    .zero(zero), .ALUOP(ALUOP), .alu_asel(alu_asel), .alu_bsel(alu_bsel),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .pc_wen(pc_wen), .pc_sel(pc_sel),
    .reg_wen(reg_wen), .reg_dst(reg_dst), .wb_sel(wb_sel), .halt(halt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_op(input string nm, input logic [5:0] opc, input logic [5:0] fn,
                        input int kind, input aluop_t aop, input logic asel,
                        input logic [1:0] bsel);
    op_t o;
    o.name = nm; o.opc = opc; o.fn = fn; o.kind = kind;
    o.aop = aop; o.asel = asel; o.bsel = bsel;
    ops.push_back(o);
  endtask

  function automatic logic [31:0] build(input op_t o);
    if (o.kind == K_R)
      return {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), o.fn};
    return {o.opc, 26'($urandom)};
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  // One instruction from FETCH back to FETCH. Expected activity comes from
  // per-class latency: FETCH (iw waits + hit), DECODE, EXECUTE, then
  // MEMORY (dw waits + hit) and/or WRITEBACK as the class requires.
  task automatic run_op(input op_t o, input logic [31:0] word,
                        input int iw, input int dw, input logic z);
    int total, ex, mem0;
    logic taken, is_mem, is_wb;
    logic [31:0] m_iren, m_pcw, m_regw, m_dren, m_dwen, m_halt;
    logic [31:0] e_pcw, e_regw, e_dren, e_dwen;
    aluop_t s_aop[32];
    logic s_asel[32];
    logic [1:0] s_bsel[32], s_pcsel[32], s_dst[32], s_wb[32];
    ex = iw + 2; mem0 = iw + 3;
    is_mem = (o.kind == K_LW) || (o.kind == K_SW);
    is_wb  = (o.kind == K_R) || (o.kind == K_I) || (o.kind == K_LW) || (o.kind == K_JAL);
    taken  = (o.kind == K_BEQ && z) || (o.kind == K_BNE && !z) ||
             (o.kind == K_J) || (o.kind == K_JAL);
    case (o.kind)
      K_LW:                total = 5 + iw + dw;
      K_SW:                total = 4 + iw + dw;
      K_BEQ, K_BNE, K_J:   total = 3 + iw;
      default:             total = 4 + iw;
    endcase
    e_pcw  = (32'd1 << iw) | (taken ? (32'd1 << ex) : 32'd0);
    e_regw = is_wb ? (32'd1 << (total - 1)) : 32'd0;
    e_dren = (o.kind == K_LW) ? (((32'd1 << (dw + 1)) - 1) << mem0) : 32'd0;
    e_dwen = (o.kind == K_SW) ? (((32'd1 << (dw + 1)) - 1) << mem0) : 32'd0;
    m_iren = '0; m_pcw = '0; m_regw = '0; m_dren = '0; m_dwen = '0; m_halt = '0;
    for (int c = 0; c < total; c++) begin
      instr = (c == iw) ? word : $urandom;
      ihit  = (c == iw) || (c > iw && $urandom_range(0, 1) == 1);
      dhit  = is_mem ? ((c == mem0 + dw) || (c < mem0 && $urandom_range(0, 1) == 1))
                     : ($urandom_range(0, 1) == 1);
      zero  = (c == ex) ? z : ($urandom_range(0, 1) == 1);
      @(negedge CLK);
      m_iren[c] = iREN; m_pcw[c] = pc_wen; m_regw[c] = reg_wen;
      m_dren[c] = dREN; m_dwen[c] = dWEN; m_halt[c] = halt;
      s_aop[c] = ALUOP; s_asel[c] = alu_asel; s_bsel[c] = alu_bsel;
      s_pcsel[c] = pc_sel; s_dst[c] = reg_dst; s_wb[c] = wb_sel;
      tick();
    end
    chk({o.name, " iREN cycles"}, m_iren, (32'd1 << (iw + 1)) - 1);
    chk({o.name, " pc_wen cycles"}, m_pcw, e_pcw);
    chk({o.name, " fetch pc_sel"}, 32'(s_pcsel[iw]), 32'(PCSEL_PC4));
    if (taken)
      chk({o.name, " exec pc_sel"}, 32'(s_pcsel[ex]),
          (o.kind == K_BEQ || o.kind == K_BNE) ? 32'd1 : 32'd2);
    chk({o.name, " reg_wen cycles"}, m_regw, e_regw);
    if (is_wb) begin
      chk({o.name, " reg_dst"}, 32'(s_dst[total - 1]),
          (o.kind == K_R) ? 32'd0 : (o.kind == K_JAL) ? 32'd2 : 32'd1);
      chk({o.name, " wb_sel"}, 32'(s_wb[total - 1]),
          (o.kind == K_LW) ? 32'd1 : (o.kind == K_JAL) ? 32'd2 : 32'd0);
    end
    chk({o.name, " dREN cycles"}, m_dren, e_dren);
    chk({o.name, " dWEN cycles"}, m_dwen, e_dwen);
    chk({o.name, " halt"}, m_halt, 32'd0);
    if (o.kind != K_J && o.kind != K_JAL) begin
      chk({o.name, " exec ALUOP"}, 32'(s_aop[ex]), 32'(o.aop));
      chk({o.name, " exec asel"}, 32'(s_asel[ex]), 32'(o.asel));
      chk({o.name, " exec bsel"}, 32'(s_bsel[ex]), 32'(o.bsel));
    end
    if (is_mem) begin
      chk({o.name, " mem ALUOP"}, 32'(s_aop[mem0 + dw]), 32'(ALU_ADD));
      chk({o.name, " mem bsel"}, 32'(s_bsel[mem0 + dw]), 32'd1);
    end
    // Must be waiting in FETCH again
    ihit = 1'b0; dhit = 1'b0;
    @(negedge CLK);
    chk({o.name, " back in FETCH"}, 32'({iREN, halt}), 32'b10);
    tick();
  endtask

  // Unsupported instruction: HALT the cycle after DECODE, then stays put
  // whatever ihit/dhit do. Ends with a reset.
  task automatic run_halt(input string nm, input logic [31:0] word,
                          input int iw, input int hold);
    for (int c = 0; c <= iw; c++) begin
      instr = (c == iw) ? word : $urandom;
      ihit  = (c == iw);
      tick();
    end
    ihit = 1'b1;
    @(negedge CLK);
    chk({nm, " decode halt"}, 32'(halt), 32'd0);
    tick();
    for (int k = 0; k < hold; k++) begin
      ihit = k[0];
      dhit = ($urandom_range(0, 1) == 1);
      zero = ($urandom_range(0, 1) == 1);
      @(negedge CLK);
      chk({nm, " halt held"}, 32'(halt), 32'd1);
      chk({nm, " enables off"}, 32'({iREN, dREN, dWEN, pc_wen, reg_wen}), 32'd0);
      tick();
    end
    do_reset();
  endtask

  initial begin
    op_t o;
    add_op("ADDU",  6'h00, 6'h21, K_R, ALU_ADD,  1'b0, 2'd0);
    add_op("SUBU",  6'h00, 6'h23, K_R, ALU_SUB,  1'b0, 2'd0);
    add_op("AND",   6'h00, 6'h24, K_R, ALU_AND,  1'b0, 2'd0);
    add_op("OR",    6'h00, 6'h25, K_R, ALU_OR,   1'b0, 2'd0);
    add_op("XOR",   6'h00, 6'h26, K_R, ALU_XOR,  1'b0, 2'd0);
    add_op("NOR",   6'h00, 6'h27, K_R, ALU_NOR,  1'b0, 2'd0);
    add_op("SLL",   6'h00, 6'h00, K_R, ALU_SLL,  1'b1, 2'd0);
    add_op("SRL",   6'h00, 6'h02, K_R, ALU_SRL,  1'b1, 2'd0);
    add_op("SLT",   6'h00, 6'h2A, K_R, ALU_SLT,  1'b0, 2'd0);
    add_op("SLTU",  6'h00, 6'h2B, K_R, ALU_SLTU, 1'b0, 2'd0);
    add_op("ADDIU", 6'h09, 6'h00, K_I, ALU_ADD,  1'b0, 2'd1);
    add_op("SLTI",  6'h0A, 6'h00, K_I, ALU_SLT,  1'b0, 2'd1);
    add_op("SLTIU", 6'h0B, 6'h00, K_I, ALU_SLTU, 1'b0, 2'd1);
    add_op("ANDI",  6'h0C, 6'h00, K_I, ALU_AND,  1'b0, 2'd2);
    add_op("ORI",   6'h0D, 6'h00, K_I, ALU_OR,   1'b0, 2'd2);
    add_op("XORI",  6'h0E, 6'h00, K_I, ALU_XOR,  1'b0, 2'd2);
    add_op("LUI",   6'h0F, 6'h00, K_I, ALU_OR,   1'b0, 2'd3);
    add_op("LW",    6'h23, 6'h00, K_LW, ALU_ADD, 1'b0, 2'd1);
    add_op("SW",    6'h2B, 6'h00, K_SW, ALU_ADD, 1'b0, 2'd1);
    add_op("BEQ",   6'h04, 6'h00, K_BEQ, ALU_SUB, 1'b0, 2'd0);
    add_op("BNE",   6'h05, 6'h00, K_BNE, ALU_SUB, 1'b0, 2'd0);
    add_op("J",     6'h02, 6'h00, K_J,   ALU_ADD, 1'b0, 2'd0);
`ifdef JAL_EN
    add_op("JAL",   6'h03, 6'h00, K_JAL, ALU_ADD, 1'b0, 2'd0);
`endif

    // Reset: outputs forced off even with hits asserted
    nRST = 1'b0; ihit = 1'b1; dhit = 1'b1; zero = 1'b1; instr = 32'hFC000000;
    tick();
    @(negedge CLK);
    chk("reset enables", 32'({iREN, dREN, dWEN, pc_wen, reg_wen, halt, alu_asel}), 32'd0);
    chk("reset selects", 32'({alu_bsel, pc_sel, reg_dst, wb_sel}), 32'd0);
    chk("reset ALUOP", 32'(ALUOP), 32'(ALU_ADD));
    tick();
    nRST = 1'b1; ihit = 1'b0; dhit = 1'b0;
    @(negedge CLK);
    chk("post-reset FETCH", 32'({iREN, halt}), 32'b10);
    tick();

    // Directed cases
    run_op(ops[0],  32'h00221821, 0, 0, 1'b0);   // ADDU
    run_op(ops[17], 32'h8C220004, 0, 2, 1'b0);   // LW, dhit 2 late
    run_op(ops[19], 32'h10220003, 0, 0, 1'b1);   // BEQ taken
    run_op(ops[19], 32'h10220003, 0, 0, 1'b0);   // BEQ not taken
    run_op(ops[20], 32'h14220003, 1, 0, 1'b0);   // BNE taken
    run_op(ops[16], 32'h3C011234, 2, 0, 1'b0);   // LUI

    // SW aborted by reset during MEMORY
    instr = 32'hAC220008; ihit = 1'b1; tick();   // FETCH
    ihit = 1'b0; tick();                         // DECODE
    tick();                                      // EXECUTE
    @(negedge CLK);
    chk("sw mem dWEN", 32'(dWEN), 32'd1);
    tick();
    nRST = 1'b0;
    @(negedge CLK);
    chk("sw abort dWEN", 32'({dWEN, dREN, pc_wen, reg_wen}), 32'd0);
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    chk("sw abort FETCH", 32'({iREN, halt}), 32'b10);
    tick();

    // Randomized stream
    for (int n = 0; n < 60; n++) begin
      o = ops[$urandom_range(0, ops.size() - 1)];
      run_op(o, build(o), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 1) == 1));
    end

    // JAL
`ifdef JAL_EN
    run_op(ops[22], 32'h0C000010, 0, 0, 1'b0);
`else
    run_halt("JAL disabled", 32'h0C000010, 0, 3);
`endif

    // Unsupported encodings
    run_halt("ADDI", 32'h20220005, 1, 3);
    run_halt("ADD",  32'h00221820, 0, 3);
    run_halt("JR",   32'h03E00008, 2, 3);
    run_halt("HALT", 32'hFC000000, 0, 20);

    // Still alive after the final reset
    run_op(ops[18], 32'hAC220008, 0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
